// File: rtl/pmem.sv
// pmem: dual-port byte-addressed memory for the Y86-64 pipeline.
// A data port (load/store with byte enables) and an instruction-fetch port
// that returns a multi-byte window. Reads are registered with RDLAT of 1 or 2.
// Fetches see same-cycle writes (write-first), and range errors are registered.
// A hold input freezes both output pipelines.
module pmem #(
    parameter int MEMBYTES = 8192,
    parameter int DBYTES   = 8,
    parameter int IBYTES   = 10,
    parameter int RDLAT    = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [63:0]           d_addr,
    input  logic [DBYTES-1:0]     d_be,
    input  logic [8*DBYTES-1:0]   d_wdata,
    output logic                  d_rvalid,
    output logic [8*DBYTES-1:0]   d_rdata,
    output logic                  d_err,
    input  logic                  i_req,
    input  logic [63:0]           i_addr,
    output logic                  i_rvalid,
    output logic [8*IBYTES-1:0]   i_instr,
    output logic                  i_err,
    input  logic                  hold
);

    localparam int AW = (MEMBYTES > 1) ? $clog2(MEMBYTES) : 1;

    logic [7:0] mem [MEMBYTES];

    // The range check is 65 bits wide so addresses near 2^64 cannot wrap back into range.
    logic [64:0] d_end, i_end;
    logic        d_ok, i_ok;
    logic        wr_en;

    assign d_end = {1'b0, d_addr} + 65'(DBYTES);
    assign i_end = {1'b0, i_addr} + 65'(IBYTES);
    assign d_ok  = d_end <= 65'(MEMBYTES);
    assign i_ok  = i_end <= 65'(MEMBYTES);

    // Hold does not block writes. A write on an edge where reset is asserted is dropped.
    assign wr_en = d_req & d_we & d_ok & resetn;

    // Commit enabled bytes of an in-range write.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int unsigned k = 0; k < DBYTES; k++) begin
                if (d_be[k]) mem[AW'(d_addr + 64'(k))] <= d_wdata[8*k +: 8];
            end
        end
    end

    logic [8*DBYTES-1:0] d_samp;
    logic [8*IBYTES-1:0] i_samp;

    // Sample the data-port bytes. An out-of-range read returns zero.
    always_comb begin
        d_samp = '0;
        if (d_ok) begin
            for (int unsigned k = 0; k < DBYTES; k++)
                d_samp[8*k +: 8] = mem[AW'(d_addr + 64'(k))];
        end
    end

    // Sample the fetch window. Bytes written in this same cycle are forwarded (write-first).
    always_comb begin
        i_samp = '0;
        if (i_ok) begin
            for (int unsigned j = 0; j < IBYTES; j++) begin
                i_samp[8*j +: 8] = mem[AW'(i_addr + 64'(j))];
                for (int unsigned k = 0; k < DBYTES; k++) begin
                    if (wr_en && d_be[k] && (d_addr + 64'(k) == i_addr + 64'(j)))
                        i_samp[8*j +: 8] = d_wdata[8*k +: 8];
                end
            end
        end
    end

    logic                d_v1, d_e1, i_v1, i_e1;
    logic [8*DBYTES-1:0] d_r1;
    logic [8*IBYTES-1:0] i_r1;

    // First output stage. Hold freezes it. Data updates only when a read or fetch is accepted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            d_v1 <= 1'b0;
            d_e1 <= 1'b0;
            d_r1 <= '0;
            i_v1 <= 1'b0;
            i_e1 <= 1'b0;
            i_r1 <= '0;
        end else if (!hold) begin
            d_v1 <= d_req & ~d_we;
            d_e1 <= d_req & ~d_ok;
            if (d_req && !d_we) d_r1 <= d_samp;
            i_v1 <= i_req;
            i_e1 <= i_req & ~i_ok;
            if (i_req) i_r1 <= i_samp;
        end
    end

    generate
        if (RDLAT == 2) begin : g_lat2
            logic                d_v2, d_e2, i_v2, i_e2;
            logic [8*DBYTES-1:0] d_r2;
            logic [8*IBYTES-1:0] i_r2;

            // Second output stage. Data moves forward only with a valid result, so the last value is kept.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    d_v2 <= 1'b0;
                    d_e2 <= 1'b0;
                    d_r2 <= '0;
                    i_v2 <= 1'b0;
                    i_e2 <= 1'b0;
                    i_r2 <= '0;
                end else if (!hold) begin
                    d_v2 <= d_v1;
                    d_e2 <= d_e1;
                    if (d_v1) d_r2 <= d_r1;
                    i_v2 <= i_v1;
                    i_e2 <= i_e1;
                    if (i_v1) i_r2 <= i_r1;
                end
            end

            assign d_rvalid = d_v2;
            assign d_err    = d_e2;
            assign d_rdata  = d_r2;
            assign i_rvalid = i_v2;
            assign i_err    = i_e2;
            assign i_instr  = i_r2;
        end else begin : g_lat1
            assign d_rvalid = d_v1;
            assign d_err    = d_e1;
            assign d_rdata  = d_r1;
            assign i_rvalid = i_v1;
            assign i_err    = i_e1;
            assign i_instr  = i_r1;
        end
    endgenerate

endmodule
